regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter NUM_RD, default 2, legal 1..4: number of independent read ports.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 reset  input  1: asynchronous, active-low reset.
REQ-006 wr_en  input  1: write request for the current cycle.
REQ-007 wr_addr  input  ADDR_W: write register index.
REQ-008 wr_data  input  DATA_W: write data.
REQ-009 rd_addr  input  NUM_RD*ADDR_W: read indices; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-010 rd_data  output  NUM_RD*DATA_W: registered read data; port p occupies bits [p*DATA_W +: DATA_W].
REQ-011 clear_start  input  1: request a sequential zeroing of all registers.
REQ-012 clear_busy  output  1: high while the clear sequence runs.
REQ-013 clear_done  output  1: one-cycle pulse when the clear sequence completes.
REQ-014 wr_drop  output  1: one-cycle pulse when a write was discarded because of a clear.

Function
REQ-015 Read latency is 1 cycle: rd_data port p after edge N = contents of rd_addr port p sampled at edge N.
REQ-016 Write: when wr_en is high at edge N in IDLE, register wr_addr takes wr_data at edge N.
REQ-017 Write-first bypass: if wr_en is high in IDLE and wr_addr equals a port's rd_addr at edge N, that port's rd_data after edge N is wr_data, not the old value.
REQ-018 Any number of read ports may address the same register in one cycle; each returns the same value.
REQ-019 The FSM has two states, IDLE and CLEAR, with a counter clr_cnt of ADDR_W bits.
REQ-020 IDLE -> CLEAR when clear_start is high at an edge; at that edge clr_cnt <= 0 and clear_busy <= 1.
REQ-021 In CLEAR, each edge writes register clr_cnt to 0 and increments clr_cnt.
REQ-022 CLEAR -> IDLE at the edge where clr_cnt = DEPTH-1; at that edge clear_busy <= 0 and clear_done <= 1.
REQ-023 clear_busy is high for exactly DEPTH cycles; clear_done is high only in the cycle after the last one.
REQ-024 The edge sampling clear_start in IDLE is not a clear cycle; a wr_en at that same edge still executes normally.
REQ-025 clear_start while in CLEAR is ignored and does not restart or extend the sequence.
REQ-026 A wr_en sampled in CLEAR is discarded; wr_drop is high for the following cycle.
REQ-027 Every rd_data port reads 0 for each edge sampled in CLEAR, regardless of address.
REQ-028 clr_cnt wraps only through the CLEAR -> IDLE transition; it never exceeds DEPTH-1.
REQ-029 clear_done and wr_drop are registered single-cycle pulses, never held.

Reset
REQ-030 While reset is low, all DEPTH registers = 0, rd_data = 0, state = IDLE, clr_cnt = 0, clear_busy = 0, clear_done = 0, wr_drop = 0, independent of clk.
REQ-031 Reset asserted during CLEAR aborts the sequence immediately and leaves the state in IDLE with all registers 0.
REQ-032 After reset deasserts, the first rising edge operates normally in IDLE.

Verification
REQ-033 Defaults: write 0xDEADBEEF to r3, next cycle read r3 on port 0 and r5 on port 1 -> port0 = 0xDEADBEEF, port1 = 0x00000000.
REQ-034 Bypass: wr_en, wr_addr = 7, wr_data = 0x12345678, rd_addr port 1 = 7 at the same edge -> port 1 = 0x12345678 after that edge.
REQ-035 Clear: fill r0..r15 with 0x100+i, pulse clear_start -> clear_busy high for 16 cycles, clear_done pulses once, then all reads return 0.
REQ-036 Write during clear: wr_en to r2 with 0xAAAA5555 in the 5th CLEAR cycle -> wr_drop pulses, and after clear_done r2 reads 0.
REQ-037 clear_start repeated in the 3rd CLEAR cycle -> busy length is still 16 cycles, with one clear_done.
REQ-038 Reset low mid-CLEAR, with no clk edge, after filling r9 = 0x55 -> clear_busy = 0 immediately, and after release r9 reads 0.

Source files
------------

// File: rtl/regfile_mp.sv
`default_nettype none
// regfile_mp -- register file, NUM_RD registered read ports, one write port, sequential clear.
// Revision 1.0
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clear_start,
  output logic                     clear_busy,
  output logic                     clear_done,
  output logic                     wr_drop
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              busy_nxt, done_nxt, drop_nxt;
  logic              user_we;
  logic [DATA_W-1:0] regs [DEPTH];

  // Writes from the port are only honoured outside the clear sequence.
  assign user_we = (state == IDLE) && wr_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      wr_drop    <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_cnt    <= clr_cnt_nxt;
      clear_busy <= busy_nxt;
      clear_done <= done_nxt;
      wr_drop    <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    busy_nxt    = clear_busy;
    done_nxt    = 1'b0;
    drop_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (clear_start) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
          busy_nxt    = 1'b1;
        end
      end
      CLEAR: begin
        drop_nxt = wr_en;
        // clear_start is deliberately not examined here: a repeat request cannot extend the run.
        if (clr_cnt == LAST_IDX) begin
          state_nxt   = IDLE;
          clr_cnt_nxt = '0;
          busy_nxt    = 1'b0;
          done_nxt    = 1'b1;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        clr_cnt_nxt = '0;
        busy_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (state == CLEAR) begin
      regs[clr_cnt] <= '0;
    end else if (user_we) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] q;

    assign addr                      = rd_addr[p*ADDR_W +: ADDR_W];
    assign rd_data[p*DATA_W +: DATA_W] = q;

    // Write-first: a same-edge write to the addressed register is forwarded.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        q <= '0;
      end else if (state == CLEAR) begin
        q <= '0;
      end else if (user_we && (wr_addr == addr)) begin
        q <= wr_data;
      end else begin
        q <= regs[addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// tb_regfile_mp -- scoreboard bench for regfile_mp with a behavioural reference model.
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 16;
  localparam int RDW    = NUM_RD * DATA_W;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     wr_en = 1'b0;
  logic [ADDR_W-1:0]        wr_addr = '0;
  logic [DATA_W-1:0]        wr_data = '0;
  logic [NUM_RD*ADDR_W-1:0] rd_addr = '0;
  logic                     clear_start = 1'b0;
  logic [RDW-1:0]           rd_data;
  logic                     clear_busy;
  logic                     clear_done;
  logic                     wr_drop;

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .wr_drop     (wr_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RDW-1:0] rd;
    logic           busy;
    logic           done;
    logic           drop;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] model [DEPTH];
  int                clr_left = 0;
  int                clr_idx  = 0;
  int                checks   = 0;
  int                errors   = 0;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    clr_left = 0;
    clr_idx  = 0;
    sb.delete();
  endtask

  // Drive one cycle, predict the outputs after the edge, push the prediction.
  task automatic step(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input logic [ADDR_W-1:0] ra0, input logic [ADDR_W-1:0] ra1, input logic cs);
    exp_t              e;
    logic [ADDR_W-1:0] ra [NUM_RD];
    wr_en       = we;
    wr_addr     = wa;
    wr_data     = wd;
    rd_addr     = {ra1, ra0};
    clear_start = cs;
    ra[0] = ra0;
    ra[1] = ra1;
    e = '0;
    if (clr_left > 0) begin
      e.rd   = '0;
      e.drop = we;
      model[clr_idx] = '0;
      clr_idx++;
      clr_left--;
      e.done = (clr_left == 0);
    end else begin
      for (int p = 0; p < NUM_RD; p++)
        e.rd[p*DATA_W +: DATA_W] = (we && wa == ra[p]) ? wd : model[ra[p]];
      if (we) model[wa] = wd;
      if (cs) begin
        clr_left = DEPTH;
        clr_idx  = 0;
      end
    end
    e.busy = (clr_left > 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({rd_data, clear_busy, clear_done, wr_drop} !== '0) begin
      errors++;
      $display("FAIL reset_async: got rd=%h busy=%b done=%b drop=%b want all 0", rd_data, clear_busy, clear_done, wr_drop);
    end
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'hFFFF_FFFF; clear_start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rd_data, clear_busy, clear_done, wr_drop} !== '0) begin
      errors++;
      $display("FAIL reset_held: got rd=%h busy=%b done=%b drop=%b want all 0", rd_data, clear_busy, clear_done, wr_drop);
    end
    wr_en = 1'b0; clear_start = 1'b0;
    model_reset();
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_defaults();
    exp_t e;
    step(1'b1, 4'd3, 32'hDEAD_BEEF, 4'd0, 4'd0, 1'b0);
    void'(sb.pop_front());
    step(1'b0, 4'd0, 32'h0, 4'd3, 4'd5, 1'b0);
    e = sb.pop_front();
    checks++;
    if (rd_data !== e.rd) begin
      errors++;
      $display("FAIL defaults_model: got %h want %h", rd_data, e.rd);
    end
    checks++;
    if (rd_data !== {32'h0000_0000, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL defaults_vec: got %h want 00000000deadbeef", rd_data);
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    step(1'b1, 4'd7, 32'h1234_5678, 4'd0, 4'd7, 1'b0);
    e = sb.pop_front();
    checks++;
    if (rd_data[DATA_W +: DATA_W] !== 32'h1234_5678 || rd_data !== e.rd) begin
      errors++;
      $display("FAIL bypass: got %h want %h", rd_data, e.rd);
    end
    step(1'b0, 4'd0, 32'h0, 4'd7, 4'd7, 1'b0);
    e = sb.pop_front();
    checks++;
    if (rd_data !== {2{32'h1234_5678}} || rd_data !== e.rd) begin
      errors++;
      $display("FAIL same_reg_ports: got %h want %h", rd_data, {2{32'h1234_5678}});
    end
  endtask

  task automatic test_random();
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom), 4'($urandom), $urandom, 4'($urandom), 4'($urandom), 1'b0);
      e = sb.pop_front();
      checks++;
      if ({rd_data, clear_busy, clear_done, wr_drop} !== e) begin
        errors++;
        $display("FAIL random[%0d]: got rd=%h flags=%b%b%b want rd=%h flags=%b%b%b", i,
                 rd_data, clear_busy, clear_done, wr_drop, e.rd, e.busy, e.done, e.drop);
      end
    end
  endtask

  task automatic test_clear();
    exp_t e;
    int   busy_n = 0;
    int   done_n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, ADDR_W'(i), 32'h100 + i, 4'd0, 4'd0, 1'b0);
      void'(sb.pop_front());
    end
    step(1'b0, 4'd0, 32'h0, 4'd4, 4'd15, 1'b1);
    e = sb.pop_front();
    checks++;
    if (rd_data !== {32'h10F, 32'h104} || clear_busy !== e.busy) begin
      errors++;
      $display("FAIL clear_start_edge: got rd=%h busy=%b want rd=0000010f00000104 busy=1", rd_data, clear_busy);
    end
    if (clear_busy) busy_n++;
    for (int i = 0; i < DEPTH + 2; i++) begin
      step(1'b0, 4'd0, 32'h0, 4'($urandom), 4'($urandom), 1'b0);
      e = sb.pop_front();
      checks++;
      if ({rd_data, clear_busy, clear_done, wr_drop} !== e) begin
        errors++;
        $display("FAIL clear_cycle[%0d]: got rd=%h flags=%b%b%b want rd=%h flags=%b%b%b", i,
                 rd_data, clear_busy, clear_done, wr_drop, e.rd, e.busy, e.done, e.drop);
      end
      if (clear_busy) busy_n++;
      if (clear_done) done_n++;
    end
    checks++;
    if (busy_n !== 16 || done_n !== 1) begin
      errors++;
      $display("FAIL clear_lengths: got busy=%0d done=%0d want busy=16 done=1", busy_n, done_n);
    end
    for (int i = 0; i < DEPTH; i += 2) begin
      step(1'b0, 4'd0, 32'h0, ADDR_W'(i), ADDR_W'(i + 1), 1'b0);
      void'(sb.pop_front());
      checks++;
      if (rd_data !== '0) begin
        errors++;
        $display("FAIL cleared_read[%0d]: got %h want 0", i, rd_data);
      end
    end
  endtask

  task automatic test_write_during_clear();
    exp_t e;
    int   drop_n = 0;
    step(1'b1, 4'd2, 32'h0BAD_F00D, 4'd0, 4'd0, 1'b0);
    void'(sb.pop_front());
    step(1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 1'b1);
    void'(sb.pop_front());
    for (int c = 1; c <= DEPTH; c++) begin
      step(c == 5, 4'd2, 32'hAAAA_5555, 4'd2, 4'd2, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({rd_data, clear_busy, clear_done, wr_drop} !== e) begin
        errors++;
        $display("FAIL wdc_cycle[%0d]: got rd=%h flags=%b%b%b want rd=%h flags=%b%b%b", c,
                 rd_data, clear_busy, clear_done, wr_drop, e.rd, e.busy, e.done, e.drop);
      end
      if (wr_drop) drop_n++;
    end
    checks++;
    if (drop_n !== 1) begin
      errors++;
      $display("FAIL wdc_drop_count: got %0d want 1", drop_n);
    end
    step(1'b0, 4'd0, 32'h0, 4'd2, 4'd2, 1'b0);
    void'(sb.pop_front());
    checks++;
    if (rd_data !== '0 || wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL wdc_r2: got rd=%h drop=%b want rd=0 drop=0", rd_data, wr_drop);
    end
  endtask

  task automatic test_clear_restart();
    exp_t e;
    int   busy_n = 0;
    int   done_n = 0;
    step(1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 1'b1);
    void'(sb.pop_front());
    if (clear_busy) busy_n++;
    for (int c = 1; c <= DEPTH + 2; c++) begin
      step(1'b0, 4'd0, 32'h0, 4'd1, 4'd6, c == 3);
      e = sb.pop_front();
      checks++;
      if ({clear_busy, clear_done, wr_drop} !== {e.busy, e.done, e.drop}) begin
        errors++;
        $display("FAIL restart_cycle[%0d]: got flags=%b%b%b want %b%b%b", c,
                 clear_busy, clear_done, wr_drop, e.busy, e.done, e.drop);
      end
      if (clear_busy) busy_n++;
      if (clear_done) done_n++;
    end
    checks++;
    if (busy_n !== 16 || done_n !== 1) begin
      errors++;
      $display("FAIL restart_lengths: got busy=%0d done=%0d want busy=16 done=1", busy_n, done_n);
    end
  endtask

  task automatic test_reset_mid_clear();
    exp_t e;
    step(1'b1, 4'd9, 32'h55, 4'd0, 4'd0, 1'b0);
    void'(sb.pop_front());
    step(1'b0, 4'd0, 32'h0, 4'd9, 4'd9, 1'b0);
    e = sb.pop_front();
    checks++;
    if (rd_data !== {2{32'h55}} || rd_data !== e.rd) begin
      errors++;
      $display("FAIL r9_fill: got %h want %h", rd_data, {2{32'h55}});
    end
    step(1'b0, 4'd0, 32'h0, 4'd9, 4'd9, 1'b1);
    void'(sb.pop_front());
    repeat (3) begin
      step(1'b0, 4'd0, 32'h0, 4'd9, 4'd9, 1'b0);
      void'(sb.pop_front());
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (clear_busy !== 1'b0 || rd_data !== '0 || clear_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear: got busy=%b done=%b rd=%h want 0 0 0", clear_busy, clear_done, rd_data);
    end
    model_reset();
    @(negedge clk) reset = 1'b1;
    step(1'b0, 4'd0, 32'h0, 4'd9, 4'd3, 1'b0);
    e = sb.pop_front();
    checks++;
    if (rd_data !== '0 || clear_busy !== 1'b0 || rd_data !== e.rd) begin
      errors++;
      $display("FAIL r9_after_reset: got rd=%h busy=%b want rd=0 busy=0", rd_data, clear_busy);
    end
    step(1'b1, 4'd4, 32'hCAFE_0004, 4'd4, 4'd0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (rd_data !== {32'h0, 32'hCAFE_0004} || rd_data !== e.rd) begin
      errors++;
      $display("FAIL first_edge_after_reset: got %h want 00000000cafe0004", rd_data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_defaults();
    test_bypass();
    test_random();
    test_clear();
    test_write_during_clear();
    test_clear_restart();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
